// File: rtl/rrd_sched_pkg.sv
// Shared types and constants for the register-read port scheduler.
// Lane requests carry source registers, register types, branch mask and payload.
package rrd_sched_pkg;

  localparam int NUM_LANES    = 3;
  localparam int NUM_RD_PORTS = 4;
  localparam int PREG_W       = 7;
  localparam int BRMASK_W     = 20;
  localparam int UOP_W        = 64;

  localparam int PSEL_W = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;
  localparam int PTR_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [1:0] RT_FIX = 2'h0;

  // rtypes packs {lrs2_rtype, lrs1_rtype}
  typedef struct packed {
    logic [PREG_W-1:0]   prs1;
    logic [PREG_W-1:0]   prs2;
    logic [3:0]          rtypes;
    logic [BRMASK_W-1:0] br_mask;
    logic [UOP_W-1:0]    uop;
  } lane_req_t;

  function automatic logic [1:0] port_need(input logic [3:0] rtypes);
    logic [1:0] n;
    n = 2'd0;
    if (rtypes[1:0] == RT_FIX) n = n + 2'd1;
    if (rtypes[3:2] == RT_FIX) n = n + 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/rrd_port_alloc.sv
// Combinational round-robin grant of whole uops against the read-port budget.
// Ports are handed out in ascending order, rs1 before rs2, in lane visit order.
module rrd_port_alloc
  import rrd_sched_pkg::*;
(
  input  logic [PTR_W-1:0]                      rr_ptr,
  input  logic [NUM_LANES-1:0]                  req_valid,
  input  logic [NUM_LANES-1:0][3:0]             req_rtypes,
  input  logic [NUM_LANES-1:0][PREG_W-1:0]      req_prs1,
  input  logic [NUM_LANES-1:0][PREG_W-1:0]      req_prs2,
  output logic [NUM_LANES-1:0]                  grant,
  output logic [NUM_RD_PORTS-1:0]               port_en,
  output logic [NUM_RD_PORTS-1:0][PREG_W-1:0]   port_addr,
  output logic [NUM_LANES-1:0][1:0][PSEL_W-1:0] port_sel,
  output logic                                  any_denied,
  output logic [PTR_W-1:0]                      first_denied
);

  logic [PSEL_W:0]  used;
  logic [PTR_W:0]   slot;
  logic [PTR_W-1:0] lane;

  // A denied lane does not block later lanes; a smaller request may slip past it.
  always_comb begin
    grant        = '0;
    port_en      = '0;
    port_addr    = '0;
    port_sel     = '0;
    any_denied   = 1'b0;
    first_denied = rr_ptr;
    used         = '0;
    slot         = '0;
    lane         = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      slot = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (slot >= (PTR_W+1)'(NUM_LANES)) begin
        slot = slot - (PTR_W+1)'(NUM_LANES);
      end
      lane = slot[PTR_W-1:0];
      if (req_valid[lane]) begin
        if ((PSEL_W+1)'(port_need(req_rtypes[lane])) <= (PSEL_W+1)'(NUM_RD_PORTS) - used) begin
          grant[lane] = 1'b1;
          if (req_rtypes[lane][1:0] == RT_FIX) begin
            port_en[used[PSEL_W-1:0]]   = 1'b1;
            port_addr[used[PSEL_W-1:0]] = req_prs1[lane];
            port_sel[lane][0]           = used[PSEL_W-1:0];
            used                        = used + 1'b1;
          end
          if (req_rtypes[lane][3:2] == RT_FIX) begin
            port_en[used[PSEL_W-1:0]]   = 1'b1;
            port_addr[used[PSEL_W-1:0]] = req_prs2[lane];
            port_sel[lane][1]           = used[PSEL_W-1:0];
            used                        = used + 1'b1;
          end
        end else if (!any_denied) begin
          any_denied   = 1'b1;
          first_denied = lane;
        end
      end
    end
  end

endmodule

// File: rtl/rrd_read_port_scheduler.sv
// Register-read port scheduler: per-lane single-entry buffers, round-robin port
// grant, branch kill/resolve, and a one-cycle stage aligned with RF read data.
module rrd_read_port_scheduler
  import rrd_sched_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_LANES-1:0]            iss_valid,
  output logic [NUM_LANES-1:0]            iss_ready,
  input  logic [NUM_LANES*PREG_W-1:0]     iss_prs1,
  input  logic [NUM_LANES*PREG_W-1:0]     iss_prs2,
  input  logic [NUM_LANES*2-1:0]          iss_lrs1_rtype,
  input  logic [NUM_LANES*2-1:0]          iss_lrs2_rtype,
  input  logic [NUM_LANES*BRMASK_W-1:0]   iss_br_mask,
  input  logic [NUM_LANES*UOP_W-1:0]      iss_uop,
  input  logic [BRMASK_W-1:0]             brupdate_resolve_mask,
  input  logic [BRMASK_W-1:0]             brupdate_mispredict_mask,
  input  logic                            flush,
  output logic [NUM_RD_PORTS*PREG_W-1:0]  rf_raddr,
  output logic [NUM_LANES-1:0]            rrd_valid,
  output logic [NUM_LANES*UOP_W-1:0]      rrd_uop,
  output logic [NUM_LANES*BRMASK_W-1:0]   rrd_br_mask,
  output logic [NUM_LANES*2*PSEL_W-1:0]   rrd_port_sel
);

  lane_req_t                             buf_q [NUM_LANES];
  lane_req_t                             in_req [NUM_LANES];
  logic [NUM_LANES-1:0]                  buf_valid_q;
  logic [NUM_LANES-1:0]                  held;
  logic [NUM_LANES-1:0]                  in_killed;
  logic [NUM_LANES-1:0]                  grant;
  logic [PTR_W-1:0]                      rr_ptr;
  logic [PTR_W-1:0]                      first_denied;
  logic                                  any_denied;

  logic [NUM_LANES-1:0][3:0]             req_rtypes;
  logic [NUM_LANES-1:0][PREG_W-1:0]      req_prs1;
  logic [NUM_LANES-1:0][PREG_W-1:0]      req_prs2;

  logic [NUM_RD_PORTS-1:0]               port_en;
  logic [NUM_RD_PORTS-1:0][PREG_W-1:0]   port_addr;
  logic [NUM_RD_PORTS-1:0][PREG_W-1:0]   raddr_q;
  logic [NUM_RD_PORTS-1:0][PREG_W-1:0]   raddr_now;
  logic [NUM_LANES-1:0][1:0][PSEL_W-1:0] port_sel;

  logic [NUM_LANES-1:0]                  rrd_valid_q;
  logic [NUM_LANES-1:0][UOP_W-1:0]       uop_q;
  logic [NUM_LANES-1:0][BRMASK_W-1:0]    mask_q;
  logic [NUM_LANES-1:0][1:0][PSEL_W-1:0] sel_q;

  // An incoming uop already hit by a mispredict is never loaded.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      held[i] = buf_valid_q[i] && !flush &&
                ((buf_q[i].br_mask & brupdate_mispredict_mask) == '0);
      req_rtypes[i] = buf_q[i].rtypes;
      req_prs1[i]   = buf_q[i].prs1;
      req_prs2[i]   = buf_q[i].prs2;

      in_req[i].prs1    = iss_prs1[i*PREG_W +: PREG_W];
      in_req[i].prs2    = iss_prs2[i*PREG_W +: PREG_W];
      in_req[i].rtypes  = {iss_lrs2_rtype[i*2 +: 2], iss_lrs1_rtype[i*2 +: 2]};
      in_req[i].br_mask = iss_br_mask[i*BRMASK_W +: BRMASK_W] & ~brupdate_resolve_mask;
      in_req[i].uop     = iss_uop[i*UOP_W +: UOP_W];
      in_killed[i]      = |(iss_br_mask[i*BRMASK_W +: BRMASK_W] & brupdate_mispredict_mask);

      iss_ready[i] = !held[i] || grant[i];
      rrd_valid[i] = rrd_valid_q[i] && ((mask_q[i] & brupdate_mispredict_mask) == '0);
    end
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      raddr_now[p] = port_en[p] ? port_addr[p] : raddr_q[p];
    end
  end

  rrd_port_alloc u_alloc (
    .rr_ptr       (rr_ptr),
    .req_valid    (held),
    .req_rtypes   (req_rtypes),
    .req_prs1     (req_prs1),
    .req_prs2     (req_prs2),
    .grant        (grant),
    .port_en      (port_en),
    .port_addr    (port_addr),
    .port_sel     (port_sel),
    .any_denied   (any_denied),
    .first_denied (first_denied)
  );

  assign rf_raddr     = raddr_now;
  assign rrd_uop      = uop_q;
  assign rrd_br_mask  = mask_q;
  assign rrd_port_sel = sel_q;

  // Grants are already empty under flush because held excludes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr      <= '0;
      buf_valid_q <= '0;
      raddr_q     <= '0;
      rrd_valid_q <= '0;
      uop_q       <= '0;
      mask_q      <= '0;
      sel_q       <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      raddr_q     <= raddr_now;
      rrd_valid_q <= grant;
      if (any_denied && !flush) begin
        rr_ptr <= first_denied;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (grant[i]) begin
          uop_q[i]  <= buf_q[i].uop;
          mask_q[i] <= buf_q[i].br_mask & ~brupdate_resolve_mask;
          sel_q[i]  <= port_sel[i];
        end
        if (flush) begin
          buf_valid_q[i] <= 1'b0;
        end else if (iss_valid[i] && iss_ready[i]) begin
          buf_valid_q[i] <= !in_killed[i];
          buf_q[i]       <= in_req[i];
        end else if (!held[i] || grant[i]) begin
          buf_valid_q[i] <= 1'b0;
        end else begin
          buf_q[i].br_mask <= buf_q[i].br_mask & ~brupdate_resolve_mask;
        end
      end
    end
  end

endmodule
